serial_link_vc_credit_sync: RTL
===============================

Name: serial_link_vc_credit_sync

Overview:
Multi-virtual-channel credit flow-control stage for the serial link TX/RX pair. It keeps per-VC available-credit and credits-to-return counters and round-robin arbitrates NumVc valid/ready input streams onto one registered output channel. Each outgoing packet carries a piggy-backed credit return for one VC. When no data can go out and returnable credits build up, it injects credits-only packets. It sits between the per-VC AXI/packetizer queues and the data link layer, replacing single-channel credit synchronization.

Parameters:
NumVc, 2, number of virtual channels (>=1)
DataWidth, 32, payload width per VC
NumCredits, 8, receiver buffer depth per VC; reset value of each available counter
ForceSendThresh, NumCredits-2, per-VC credits-to-send level that triggers a credits-only packet (1..NumCredits)
CredW, $clog2(NumCredits+1), credit field width (derived, do not override)
VcW, (NumVc>1)?$clog2(NumVc):1, VC index width (derived)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
data_i  in  NumVc*DataWidth  per-VC payload, VC v at [v*DataWidth +: DataWidth]
valid_i  in  NumVc  per-VC payload valid
ready_o  out  NumVc  per-VC payload accepted
data_o  out  DataWidth  registered payload, zero for credits-only packets
vc_o  out  VcW  VC of the payload
cred_vc_o  out  VcW  VC whose credits are returned in credits_o
credits_o  out  CredW  credits returned to the remote side
credits_only_o  out  1  packet carries no payload
valid_o  out  1  output packet valid
ready_i  in  1  downstream ready
credits_valid_i  in  1  remote credit return arrives this cycle
cred_vc_i  in  VcW  VC of the received credits
credits_i  in  CredW  number of received credits
buf_release_i  in  NumVc  one-cycle pulse per entry freed from the local RX buffer of VC v
stall_cnt_o  out  NumVc*16  per-VC credit-stall counters (see Optional Feature)

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge): avail[v]=NumCredits, tosend[v]=0, RR pointer=0, valid_o=0, data_o=0, vc_o=0, cred_vc_o=0, credits_o=0, credits_only_o=0, ready_o=0. Reset mid-packet drops the pending output without a handshake.
- Output register "free" = ~valid_o | ready_i. A load happens only when free. Otherwise all output fields stay stable.
- Credit selection, combinational: sel = VC with the largest tosend, lowest index on ties; amt = tosend[sel].
- Data eligibility of VC v: valid_i[v] & (avail[v]>=2 | (avail[v]==1 & amt>0)). The last credit is never spent without a credit return, which prevents deadlock.
- Grant: round-robin among eligible VCs, starting at RR pointer. ready_o[v] = grant[v] & free, and only one bit is ever set. On a load, the pointer moves to grant+1 modulo NumVc.
- Data load: data_o=data_i[g], vc_o=g, credits_only_o=0, cred_vc_o=sel, credits_o=amt, valid_o=1. avail[g] decrements by 1 and tosend[sel] drops by amt in the same cycle.
- Credits-only load: happens when free, no VC is eligible, and max tosend >= ForceSendThresh. Sets data_o=0, credits_only_o=1, vc_o=sel, cred_vc_o=sel, credits_o=amt, and consumes no avail credit. Credits-only packets are never buffered remotely.
- Otherwise, when free: valid_o=0. credits_o and credits_only_o are cleared.
- Latency: valid_i to valid_o is 1 cycle when credits are available.
- Counter updates in one cycle are net: avail[v] gets +credits_i (if credits_valid_i and cred_vc_i==v) −1 (data load on v). tosend[v] gets +buf_release_i[v] −amt (if sel==v at load). A release on the loading cycle is kept in the counter; nothing is lost.
- Width: all counters are CredW and never wrap. An assertion fires if avail[v]>NumCredits or tosend[v]>NumCredits.

Optional Feature:
Macro SERIAL_LINK_VC_CRED_STATS_EN.
- Defined: stall_cnt_o[v] is a 16-bit saturating counter. It increments each cycle valid_i[v]=1 while VC v is not data-eligible because of its credit state. It clears on reset and holds at 0xFFFF.
- Undefined: stall_cnt_o is tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset, then valid_i=2'b11, ready_i=1, no releases → packets alternate VC0/VC1. Each VC sends 7 packets, stalls at avail=1; valid_o drops after 14 packets.
- VC0 only, avail[0]=1, single buf_release_i[1] pulse → the next VC0 packet goes out with cred_vc_o=1 and credits_o=1, and avail[0] becomes 0.
- No valid_i, 6 release pulses on VC1 (NumCredits=8) → one credits-only packet: data_o=0, cred_vc_o=1, credits_o=6, and avail is unchanged.
- ready_i=0 for 5 cycles with valid_o=1 and 3 releases on VC0 → output fields are held. After ready_i=1, the following packet carries credits_o=3.
- credits_valid_i with cred_vc_i=0, credits_i=2 in the same cycle as a VC0 data load at avail[0]=4 → avail[0]=5 next cycle.
- Stats build: VC1 held credit-starved for 10 cycles with valid_i[1]=1 → stall_cnt_o[1]=10. Non-stats build → stall_cnt_o reads 0.

Source files
------------

// File: rtl/serial_link_vc_credit_sync.sv
// Multi-VC credit flow control: per-VC credit counters, round-robin data arbitration, piggy-backed and credits-only returns.
// Latency: valid_i to valid_o is one cycle when the VC holds credits; the output register is loaded only when it is free.
// Backpressure: ready_o goes to at most one VC, and only while the output register is empty or ready_i is high.
// Optional per-VC credit-stall counters are enabled by defining SERIAL_LINK_VC_CRED_STATS_EN.
module serial_link_vc_credit_sync #(
    parameter int NumVc           = 2,
    parameter int DataWidth       = 32,
    parameter int NumCredits      = 8,
    parameter int ForceSendThresh = NumCredits - 2,
    parameter int CredW           = $clog2(NumCredits + 1),
    parameter int VcW             = (NumVc > 1) ? $clog2(NumVc) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumVc*DataWidth-1:0] data_i,
    input  logic [NumVc-1:0]           valid_i,
    output logic [NumVc-1:0]           ready_o,
    output logic [DataWidth-1:0]       data_o,
    output logic [VcW-1:0]             vc_o,
    output logic [VcW-1:0]             cred_vc_o,
    output logic [CredW-1:0]           credits_o,
    output logic                       credits_only_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    input  logic                       credits_valid_i,
    input  logic [VcW-1:0]             cred_vc_i,
    input  logic [CredW-1:0]           credits_i,
    input  logic [NumVc-1:0]           buf_release_i,
    output logic [NumVc*16-1:0]        stall_cnt_o
);

    logic [CredW-1:0] avail_q  [NumVc];
    logic [CredW-1:0] tosend_q [NumVc];
    logic [CredW:0]   avail_nxt  [NumVc];
    logic [CredW:0]   tosend_nxt [NumVc];
    logic [VcW-1:0]   rr_q;

    logic [VcW-1:0]   sel;
    logic [CredW-1:0] amt;
    logic [NumVc-1:0] credit_ok;
    logic [NumVc-1:0] elig;
    logic [VcW-1:0]   grant;
    logic             grant_vld;
    logic             free;
    logic             load_data;
    logic             load_cred;

    // Credit return target: fullest credits-to-send counter, lowest index wins ties.
    always_comb begin
        sel = '0;
        amt = tosend_q[0];
        for (int v = 1; v < NumVc; v++) begin
            if (tosend_q[v] > amt) begin
                sel = VcW'(v);
                amt = tosend_q[v];
            end
        end
    end

    // The last remote credit may only be spent when this packet also returns credits.
    always_comb begin
        for (int v = 0; v < NumVc; v++) begin
            credit_ok[v] = ({1'b0, avail_q[v]} >= (CredW+1)'(2)) ||
                           ((avail_q[v] == CredW'(1)) && (amt != '0));
            elig[v]      = valid_i[v] & credit_ok[v];
        end
    end

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int i = 0; i < NumVc; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NumVc;
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant     = VcW'(idx);
            end
        end
    end

    assign free      = ~valid_o | ready_i;
    assign load_data = free & grant_vld;
    assign load_cred = free & ~grant_vld & ({1'b0, amt} >= (CredW+1)'(ForceSendThresh));

    always_comb begin
        for (int v = 0; v < NumVc; v++) begin
            ready_o[v] = ~rst_i & load_data & (grant == VcW'(v));
        end
    end

    // Net per-cycle counter updates; a release on the cycle its VC's credits go out is kept.
    always_comb begin
        for (int v = 0; v < NumVc; v++) begin
            avail_nxt[v] = {1'b0, avail_q[v]}
                         + ((credits_valid_i && (cred_vc_i == VcW'(v))) ? {1'b0, credits_i} : '0)
                         - ((load_data && (grant == VcW'(v))) ? (CredW+1)'(1) : '0);
            tosend_nxt[v] = {1'b0, tosend_q[v]}
                          + (CredW+1)'(buf_release_i[v])
                          - (((load_data || load_cred) && (sel == VcW'(v))) ? {1'b0, amt} : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int v = 0; v < NumVc; v++) begin
                avail_q[v]  <= CredW'(NumCredits);
                tosend_q[v] <= '0;
            end
            rr_q           <= '0;
            valid_o        <= 1'b0;
            data_o         <= '0;
            vc_o           <= '0;
            cred_vc_o      <= '0;
            credits_o      <= '0;
            credits_only_o <= 1'b0;
        end else begin
            for (int v = 0; v < NumVc; v++) begin
                avail_q[v]  <= avail_nxt[v][CredW-1:0];
                tosend_q[v] <= tosend_nxt[v][CredW-1:0];
            end
            if (load_data) begin
                valid_o        <= 1'b1;
                data_o         <= data_i[int'(grant)*DataWidth +: DataWidth];
                vc_o           <= grant;
                cred_vc_o      <= sel;
                credits_o      <= amt;
                credits_only_o <= 1'b0;
                rr_q           <= (grant == VcW'(NumVc - 1)) ? '0 : grant + VcW'(1);
            end else if (load_cred) begin
                valid_o        <= 1'b1;
                data_o         <= '0;
                vc_o           <= sel;
                cred_vc_o      <= sel;
                credits_o      <= amt;
                credits_only_o <= 1'b1;
            end else if (free) begin
                valid_o        <= 1'b0;
                credits_o      <= '0;
                credits_only_o <= 1'b0;
            end
        end
    end

    for (genvar v = 0; v < NumVc; v++) begin : g_bound_chk
        a_avail_bound: assert property (@(posedge clk_i) disable iff (rst_i)
            avail_nxt[v] <= (CredW+1)'(NumCredits));
        a_tosend_bound: assert property (@(posedge clk_i) disable iff (rst_i)
            tosend_nxt[v] <= (CredW+1)'(NumCredits));
    end

`ifdef SERIAL_LINK_VC_CRED_STATS_EN
    logic [15:0] stall_q [NumVc];

    always_ff @(posedge clk_i) begin
        for (int v = 0; v < NumVc; v++) begin
            if (rst_i) begin
                stall_q[v] <= '0;
            end else if (valid_i[v] && !credit_ok[v] && (stall_q[v] != 16'hFFFF)) begin
                stall_q[v] <= stall_q[v] + 16'd1;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NumVc; v++) begin
            stall_cnt_o[v*16 +: 16] = stall_q[v];
        end
    end
`else
    assign stall_cnt_o = '0;
`endif

endmodule
